// File: rtl/game_stats_tracker_pkg.sv
// game_stats_tracker_pkg: shared widths, defaults and FSM state encoding
package game_stats_tracker_pkg;
  localparam int TOTAL_PAIRS_DEF = 8;
  localparam int GAME_TIME_W = 13;
  localparam int SEC_W = 6;
  localparam int HSEC_W = 7;
  localparam int PAIRS_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, OVER = 2'd2} state_t;
endpackage

// File: rtl/game_stats_tracker_if.sv
// game_stats_tracker_if: control pulses in, endgame statistics out
interface game_stats_tracker_if;
  import game_stats_tracker_pkg::*;
  logic game_start;
  logic pair_found;
  logic game_abort;
  logic [GAME_TIME_W-1:0] game_time;
  logic [PAIRS_W-1:0] discovered_pairs_ctr;
  logic game_over_en;
  logic running;
  modport master(output game_start, pair_found, game_abort,
                 input game_time, discovered_pairs_ctr, game_over_en, running);
  modport slave(input game_start, pair_found, game_abort,
                output game_time, discovered_pairs_ctr, game_over_en, running);
endinterface

// File: rtl/game_stats_tracker_tick_gen_100hz.sv
// tick_gen_100hz: prescaler emitting a one-cycle tick every TICK_DIV enabled cycles
module tick_gen_100hz #(
  parameter int TICK_DIV = 650_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge pclk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/game_stats_tracker.sv
// game_stats_tracker: game timer, pair counter and game-over flag for the endgame popup
module game_stats_tracker
  import game_stats_tracker_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int TOTAL_PAIRS = TOTAL_PAIRS_DEF,
  parameter int MAX_SECONDS = 63
) (
  input logic pclk,
  input logic rst,
  game_stats_tracker_if.slave bus
);
  localparam int TICK_DIV = CLK_FREQ_HZ / 100;
  state_t state;
  logic [SEC_W-1:0] sec;
  logic [HSEC_W-1:0] hsec;
  logic [PAIRS_W-1:0] pairs;
  logic tick, sat, hwrap, last_pair;
  tick_gen_100hz #(.TICK_DIV(TICK_DIV)) u_tick (
    .pclk(pclk),
    .rst (rst),
    .clr (bus.game_start),
    .en  (state == RUNNING),
    .tick(tick)
  );
  assign hwrap = hsec == HSEC_W'(99);
  assign sat = sec == SEC_W'(MAX_SECONDS) && hwrap;
  assign last_pair = bus.pair_found && pairs == PAIRS_W'(TOTAL_PAIRS - 1);
  // start wins over every other event and restarts from any state
  always_ff @(posedge pclk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sec <= '0;
      hsec <= '0;
      pairs <= '0;
      bus.running <= 1'b0;
      bus.game_over_en <= 1'b0;
    end else if (bus.game_start) begin
      state <= RUNNING;
      sec <= '0;
      hsec <= '0;
      pairs <= '0;
      bus.running <= 1'b1;
      bus.game_over_en <= 1'b0;
    end else if (state == RUNNING) begin
      if (tick && !sat) begin
        hsec <= hwrap ? '0 : hsec + 1'b1;
        if (hwrap) sec <= sec + 1'b1;
      end
      if (bus.pair_found) pairs <= pairs + 1'b1;
      if (bus.game_abort || last_pair) begin
        state <= OVER;
        bus.running <= 1'b0;
        bus.game_over_en <= 1'b1;
      end
    end
  assign bus.game_time = {sec, hsec};
  assign bus.discovered_pairs_ctr = pairs;
endmodule
